// File: rtl/matrix_scalar_seq_if.sv
// Start/busy/done handshake plus operand and result matrices for matrix_scalar_seq.
// The sticky sat flag exists only when MATRIX_SCALAR_SEQ_SAT_EN is defined.
interface matrix_scalar_seq_if #(
    parameter int unsigned ROWS = 3,
    parameter int unsigned COLS = 2,
    parameter int unsigned W    = 4
);
    logic                   start;
    logic [ROWS*COLS*W-1:0] A;
    logic [W-1:0]           a;
    logic                   busy;
    logic                   done;
    logic [ROWS*COLS*W-1:0] B;
`ifdef MATRIX_SCALAR_SEQ_SAT_EN
    logic                   sat;

    modport master (output start, A, a, input busy, done, B, sat);
    modport slave  (input start, A, a, output busy, done, B, sat);
`else
    modport master (output start, A, a, input busy, done, B);
    modport slave  (input start, A, a, output busy, done, B);
`endif
endinterface

// File: rtl/matrix_scalar_seq.sv
// Matrix-by-scalar through one shared signed multiplier, one element per clock.
// Optional clamp-to-range rescale and sticky sat flag: MATRIX_SCALAR_SEQ_SAT_EN.
module matrix_scalar_seq #(
    parameter int unsigned ROWS = 3,
    parameter int unsigned COLS = 2,
    parameter int unsigned W    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    matrix_scalar_seq_if.slave  bus
);
    localparam int unsigned N  = ROWS * COLS;
    localparam int unsigned NW = N * W;
    localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned IW = (NW > 1) ? $clog2(NW) : 1;

    typedef enum logic [1:0] {StIdle, StMul, StFin} state_e;

    state_e         state_q, state_d;
    logic [KW-1:0]  k_q, k_d;
    logic [NW-1:0]  mat_q, mat_d;
    logic [W-1:0]   scl_q, scl_d;
    logic [NW-1:0]  b_q, b_d;
    logic           sat_q, sat_d;

    logic           last;
    logic [IW-1:0]  base;
    logic [W-1:0]   elem;
    logic [2*W-1:0] prod;
    logic [W-1:0]   res;
    logic           clip;

`ifdef MATRIX_SCALAR_SEQ_SAT_EN
    localparam logic signed [2*W-1:0] SatMax = {{(W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [2*W-1:0] SatMin = {{(W+1){1'b1}}, {(W-1){1'b0}}};
    logic signed [2*W-1:0] shr;
    logic                  unused_prod_lsb;
    assign unused_prod_lsb = prod[0];
`else
    logic                  unused_prod_mid;
    assign unused_prod_mid = ^prod[2*W-2:W];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            k_q     <= '0;
            mat_q   <= '0;
            scl_q   <= '0;
            b_q     <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            mat_q   <= mat_d;
            scl_q   <= scl_d;
            b_q     <= b_d;
            sat_q   <= sat_d;
        end
    end

    assign last = (k_q == KW'(N - 1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.start) state_d = StMul;
            StMul:   if (last) state_d = StFin;
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Element k sits at slot N-1-k so that element (0,0) lands in the MSBs.
    always_comb begin
        base = IW'((N - 1 - 32'(k_q)) * W);
        elem = mat_q[base +: W];
        prod = {{W{scl_q[W-1]}}, scl_q} * {{W{elem[W-1]}}, elem};
        clip = 1'b0;
`ifdef MATRIX_SCALAR_SEQ_SAT_EN
        shr = {prod[2*W-1], prod[2*W-1:1]};
        if (shr > SatMax) begin
            res  = SatMax[W-1:0];
            clip = 1'b1;
        end else if (shr < SatMin) begin
            res  = SatMin[W-1:0];
            clip = 1'b1;
        end else begin
            res = shr[W-1:0];
        end
`else
        res = {prod[2*W-1], prod[W-1:1]};
`endif
    end

    always_comb begin
        k_d   = k_q;
        mat_d = mat_q;
        scl_d = scl_q;
        b_d   = b_q;
        sat_d = sat_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    mat_d = bus.A;
                    scl_d = bus.a;
                    k_d   = '0;
                    sat_d = 1'b0;
                end
            end
            StMul: begin
                b_d[base +: W] = res;
                k_d            = last ? '0 : k_q + KW'(1);
                sat_d          = sat_q | clip;
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.busy = (state_q == StMul);
        bus.done = (state_q == StFin);
        bus.B    = b_q;
`ifdef MATRIX_SCALAR_SEQ_SAT_EN
        bus.sat  = sat_q;
`endif
    end

endmodule

// File: tb/tb_matrix_scalar_seq.sv
// Randomised self-checking bench for matrix_scalar_seq against an arithmetic reference model.
// Define MATRIX_SCALAR_SEQ_SAT_EN for both files to exercise the saturating build.
module tb_matrix_scalar_seq;
    localparam int ROWS = 3;
    localparam int COLS = 2;
    localparam int W    = 4;
    localparam int N    = ROWS * COLS;
    localparam int BW   = N * W;
    localparam int HALF = 2 ** (W - 1);

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    matrix_scalar_seq_if #(.ROWS(ROWS), .COLS(COLS), .W(W)) bus ();

    matrix_scalar_seq #(.ROWS(ROWS), .COLS(COLS), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sx(input logic [W-1:0] v);
        return v[W-1] ? int'(v) - 2 ** W : int'(v);
    endfunction

    function automatic int floor_half(input int p);
        return (p >= 0) ? p / 2 : -((-p + 1) / 2);
    endfunction

    // Value of one result element as a signed integer, from plain arithmetic on the product.
    function automatic int exp_res(input int sa, input int se);
        int p, q, m;
        p = sa * se;
        q = floor_half(p);
`ifdef MATRIX_SCALAR_SEQ_SAT_EN
        m = 0;
        if (q > HALF - 1) return HALF - 1;
        if (q < -HALF) return -HALF;
        return q;
`else
        m = q % HALF;
        if (m < 0) m += HALF;
        return (p < 0) ? m - HALF : m;
`endif
    endfunction

    function automatic bit exp_clip(input int sa, input int se);
        int q;
        q = floor_half(sa * se);
        return (q > HALF - 1) || (q < -HALF);
    endfunction

    function automatic logic [BW-1:0] exp_pack(input logic [BW-1:0] ma, input logic [W-1:0] sa);
        logic [BW-1:0] tmp, out;
        logic [31:0]   rv;
        tmp = ma;
        out = '0;
        for (int k = 0; k < N; k++) begin
            rv  = exp_res(sx(sa), sx(tmp[BW-1 -: W]));
            out = {out[BW-W-1:0], rv[W-1:0]};
            tmp = tmp << W;
        end
        return out;
    endfunction

    function automatic logic [BW-1:0] rand_mat();
        logic [BW-1:0] m;
        logic [31:0]   r;
        m = '0;
        for (int k = 0; k < N; k++) begin
            r = $urandom;
            m = {m[BW-W-1:0], r[W-1:0]};
        end
        return m;
    endfunction

    // Reference timeline: m_cnt counts edges since the accepted start edge.
    bit   m_run = 0;
    int   m_cnt = 0;
    int   m_sc  = 0;
    int   m_lat [N];
    int   m_res [N];
    bit   m_sat = 0;

    always @(posedge clk or negedge rst_n) begin
        logic [BW-1:0] tmp;
        if (!rst_n) begin
            m_run = 0;
            m_cnt = 0;
            m_sat = 0;
            for (int k = 0; k < N; k++) m_res[k] = 0;
        end else if (m_run) begin
            m_cnt++;
            if (m_cnt <= N) begin
                m_res[m_cnt-1] = exp_res(m_sc, m_lat[m_cnt-1]);
                if (exp_clip(m_sc, m_lat[m_cnt-1])) m_sat = 1;
            end
            if (m_cnt == N + 1) m_run = 0;
        end else if (bus.start) begin
            m_run = 1;
            m_cnt = 0;
            m_sat = 0;
            m_sc  = sx(bus.a);
            tmp   = bus.A;
            for (int k = 0; k < N; k++) begin
                m_lat[k] = sx(tmp[BW-1 -: W]);
                tmp      = tmp << W;
            end
        end
    end

    function automatic logic [BW-1:0] model_b();
        logic [BW-1:0] out;
        logic [31:0]   rv;
        out = '0;
        for (int k = 0; k < N; k++) begin
            rv  = m_res[k];
            out = {out[BW-W-1:0], rv[W-1:0]};
        end
        return out;
    endfunction

    always @(negedge clk) begin
        check("cyc_busy", BW'(bus.busy), BW'(m_run && m_cnt < N));
        check("cyc_done", BW'(bus.done), BW'(m_run && m_cnt == N));
        check("cyc_B", bus.B, model_b());
`ifdef MATRIX_SCALAR_SEQ_SAT_EN
        check("cyc_sat", BW'(bus.sat), BW'(m_sat));
`endif
    end

    task automatic run(input logic [BW-1:0] ma, input logic [W-1:0] sa, input bit scramble,
                       input logic [BW-1:0] want, input string tag);
        int busy_n, done_at;
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = ma;
        bus.a     = sa;
        @(negedge clk);
        bus.start = 1'b0;
        busy_n    = 0;
        done_at   = 0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (bus.busy) busy_n++;
            if (bus.done) begin
                done_at = cyc;
                break;
            end
            if (scramble) begin
                bus.A     = rand_mat();
                bus.a     = W'($urandom);
                bus.start = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        check({tag, "_busy_cycles"}, BW'(busy_n), BW'(N));
        check({tag, "_done_cycle"}, BW'(done_at), BW'(N + 1));
        check({tag, "_B"}, bus.B, want);
    endtask

    initial begin
        logic [BW-1:0] ma;
        logic [W-1:0]  sa;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.a     = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_B", bus.B, '0);
        check("rst_busy", BW'(bus.busy), '0);
        check("rst_done", BW'(bus.done), '0);
        rst_n = 1'b1;

        // Pin the reference model with hand-worked values.
        check("model_2x3", BW'(exp_res(3, 2)), BW'(3));
        check("model_m2x3", BW'(exp_res(3, -2)), BW'(-3));
        check("model_7x7", BW'(exp_pack(24'h780000, 4'd7)),
`ifdef MATRIX_SCALAR_SEQ_SAT_EN
              24'h780000);
`else
              24'h0C0000);
`endif

        run(24'h222222, 4'd3, 1'b0, 24'h333333, "all2");
`ifdef MATRIX_SCALAR_SEQ_SAT_EN
        check("all2_sat", BW'(bus.sat), '0);
`endif
        run(24'hE11111, 4'd3, 1'b0, 24'hD11111, "neg00");
`ifdef MATRIX_SCALAR_SEQ_SAT_EN
        run(24'h780000, 4'd7, 1'b0, 24'h780000, "ovf");
        check("ovf_sat", BW'(bus.sat), BW'(1));
        run(24'h888888, 4'h8, 1'b0, 24'h777777, "minmin");
`else
        run(24'h780000, 4'd7, 1'b0, 24'h0C0000, "ovf");
        run(24'h888888, 4'h8, 1'b0, 24'h000000, "minmin");
`endif
        run(rand_mat(), 4'd0, 1'b0, 24'h000000, "zero_a");

        for (int i = 0; i < 12; i++) begin
            ma = rand_mat();
            sa = W'($urandom);
            run(ma, sa, 1'(i % 2), exp_pack(ma, sa), "rand");
        end

        // Abort partway through a run, then confirm the next run is clean.
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = rand_mat();
        bus.a     = W'($urandom);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_B", bus.B, '0);
        check("abort_busy", BW'(bus.busy), '0);
        check("abort_done", BW'(bus.done), '0);
        @(negedge clk);
        rst_n = 1'b1;
        ma = rand_mat();
        sa = W'($urandom);
        run(ma, sa, 1'b0, exp_pack(ma, sa), "after_abort");
        run(24'h222222, 4'd3, 1'b0, 24'h333333, "after_abort2");

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
